// File: rtl/spi_host_pkg.sv
// Shared types and constants for the byte-oriented SPI mode-0 host master.
package spi_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP,
        HOLD,
        GUARD
    } state_t;

    localparam int   SPI_BYTE_W  = 8;
    localparam logic SCK_IDLE    = 1'b0;
    localparam logic SS_INACTIVE = 1'b1;

endpackage

// File: rtl/spi_host_master_if.sv
// Byte stream handshake between a host and the SPI master (tx in, rx out).
interface spi_host_master_if;
    import spi_host_pkg::*;

    logic                  tx_valid;
    logic [SPI_BYTE_W-1:0] tx_data;
    logic                  tx_last;
    logic                  tx_ready;
    logic                  rx_valid;
    logic [SPI_BYTE_W-1:0] rx_data;

    modport master (
        output tx_valid, tx_data, tx_last,
        input  tx_ready, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data, tx_last,
        output tx_ready, rx_valid, rx_data
    );

endinterface

// File: rtl/spi_sck_gen.sv
// Phase counter: pulses phase_done on the last cycle of every CLK_DIV-cycle phase.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    output logic phase_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        phase_done = en && (cnt_q == CNT_MAX);
        cnt_d      = cnt_q;
        if (!en || clr || phase_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_host_master.sv
// SPI mode-0 master: turns a valid/ready byte stream into SS-framed transfers
// and returns every MISO byte on a one-cycle rx_valid strobe.
module spi_host_master
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    spi_host_master_if.slave   bus,
    output logic               busy,
    output logic               SCK,
    output logic               SS,
    output logic               MOSI,
    input  logic               MISO
);

    state_t                state_q, state_d;
    logic [SPI_BYTE_W-1:0] tx_sr_q, tx_sr_d;
    logic [SPI_BYTE_W-1:0] rx_sr_q, rx_sr_d;
    logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  last_q, last_d;
    logic                  miso_s1_q, miso_s1_d;
    logic                  miso_s2_q, miso_s2_d;

    logic                  tx_ready;
    logic                  accept;
    logic                  phase_en;
    logic                  phase_done;
    logic [SPI_BYTE_W-1:0] rx_shift;

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (phase_en),
        .clr        (state_d != state_q),
        .phase_done (phase_done)
    );

    always_comb begin
        tx_ready = (state_q == IDLE) || (state_q == GAP);
        accept   = bus.tx_valid && tx_ready;
        phase_en = state_q inside {SETUP, HIGH, LOW, HOLD, GUARD};
        busy     = (state_q != IDLE);
        SCK      = (state_q == HIGH) ? ~SCK_IDLE : SCK_IDLE;
        SS       = (state_q == IDLE || state_q == GUARD) ? SS_INACTIVE : ~SS_INACTIVE;
        MOSI     = (state_q inside {SETUP, HIGH, LOW}) ? tx_sr_q[SPI_BYTE_W-1] : 1'b0;
        rx_shift = {rx_sr_q[SPI_BYTE_W-2:0], miso_s2_q};
    end

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        last_d     = last_q;
        miso_s1_d  = MISO;
        miso_s2_d  = miso_s1_q;

        case (state_q)
            IDLE, GAP: begin
                if (accept) begin
                    tx_sr_d   = bus.tx_data;
                    last_d    = bus.tx_last;
                    bit_cnt_d = 3'd0;
                    state_d   = SETUP;
                end
            end
            SETUP: if (phase_done) state_d = HIGH;
            HIGH: begin
                // MISO is sampled on the final high cycle, after the synchronizer has settled
                if (phase_done) begin
                    rx_sr_d = rx_shift;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = rx_shift;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = 3'd0;
                        state_d    = last_q ? HOLD : GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_sr_d   = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
                        state_d   = LOW;
                    end
                end
            end
            LOW:     if (phase_done) state_d = HIGH;
            HOLD:    if (phase_done) state_d = GUARD;
            GUARD:   if (phase_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            bit_cnt_q  <= 3'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            bit_cnt_q  <= bit_cnt_d;
            last_q     <= last_d;
        end
    end

    // Shift registers and synchronizer carry no reset; MOSI is gated by state.
    always_ff @(posedge clk) begin
        tx_sr_q   <= tx_sr_d;
        rx_sr_q   <= rx_sr_d;
        miso_s1_q <= miso_s1_d;
        miso_s2_q <= miso_s2_d;
    end

    assign bus.tx_ready = tx_ready;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_host_master.sv
// Scoreboard bench for spi_host_master: D=4 instance for protocol/timing, D=2 for frame spacing.
module tb_spi_host_master;
    import spi_host_pkg::*;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_host_master_if bus4 ();
    spi_host_master_if bus2 ();
    logic busy4, sck4, ss4, mosi4, miso4;
    logic busy2, sck2, ss2, mosi2, miso2;

    spi_host_master #(.CLK_DIV(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .bus(bus4), .busy(busy4),
        .SCK(sck4), .SS(ss4), .MOSI(mosi4), .MISO(miso4)
    );

    spi_host_master #(.CLK_DIV(2)) dut2 (
        .clk(clk), .n_rst(n_rst), .bus(bus2), .busy(busy2),
        .SCK(sck2), .SS(ss2), .MOSI(mosi2), .MISO(miso2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- reference model and scoreboard, D=4 ----------------
    logic [7:0] exp_mosi_q[$];
    logic [7:0] exp_rx_q[$];
    logic [8:0] miso_q[$];      // {last_of_frame, reply byte}
    logic [8:0] cur4 = '0;
    logic [7:0] mosi_cap4 = '0;
    int bits4 = 0;
    int sck_rises4 = 0;
    int rx_cnt4 = 0;
    int rx_cyc4 = 0;
    int ss_rise_cyc4 = 0;
    int ready_rise_cyc4 = 0;
    logic ss_prev4 = 1'b1;
    logic ready_prev4 = 1'b1;

    task automatic load4();
        if (miso_q.size() > 0) cur4 = miso_q.pop_front();
        else cur4 = '0;
        miso4 = cur4[7];
    endtask

    initial miso4 = 1'b0;

    always @(negedge ss4) if (n_rst) load4();

    always @(posedge ss4) begin
        bits4 = 0;
        miso4 = 1'b0;
    end

    always @(negedge sck4) begin
        if (n_rst && !ss4) begin
            if (bits4 == 0) begin
                if (!cur4[8]) load4();
                else miso4 = 1'b0;
            end else begin
                cur4[7:0] = cur4[7:0] << 1;
                miso4 = cur4[7];
            end
        end
    end

    always @(posedge sck4) begin
        sck_rises4++;
        mosi_cap4 = {mosi_cap4[6:0], mosi4};
        bits4++;
        if (bits4 == 8) begin
            bits4 = 0;
            if (exp_mosi_q.size() == 0) fail_now("mosi_unexpected_byte");
            else chk("mosi_byte", mosi_cap4, exp_mosi_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (bus4.rx_valid) begin
            rx_cnt4++;
            rx_cyc4 = cyc;
            if (exp_rx_q.size() == 0) fail_now("rx_unexpected_strobe");
            else chk("rx_data", bus4.rx_data, exp_rx_q.pop_front());
        end
        if (ss4 && !ss_prev4) ss_rise_cyc4 = cyc;
        if (bus4.tx_ready && !ready_prev4) ready_rise_cyc4 = cyc;
        ss_prev4 = ss4;
        ready_prev4 = bus4.tx_ready;
    end

    // ---------------- reference model and scoreboard, D=2 ----------------
    logic [7:0] exp_rx2_q[$];
    logic [7:0] exp_mosi2_q[$];
    logic [7:0] rep2 = '0;
    logic [7:0] sh2 = '0;
    logic [7:0] mosi_cap2 = '0;
    int bits2 = 0;
    int run2 = 0;

    initial miso2 = 1'b0;

    always @(negedge ss2) if (n_rst) begin
        sh2 = rep2;
        miso2 = sh2[7];
        bits2 = 0;
    end

    always @(negedge sck2) if (n_rst && !ss2) begin
        sh2 = sh2 << 1;
        miso2 = sh2[7];
    end

    always @(posedge sck2) begin
        mosi_cap2 = {mosi_cap2[6:0], mosi2};
        bits2++;
        if (bits2 == 8) begin
            bits2 = 0;
            if (exp_mosi2_q.size() == 0) fail_now("mosi_d2_unexpected_byte");
            else chk("mosi_byte_d2", mosi_cap2, exp_mosi2_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (bus2.rx_valid) begin
            if (exp_rx2_q.size() == 0) fail_now("rx_d2_unexpected_strobe");
            else chk("rx_data_d2", bus2.rx_data, exp_rx2_q.pop_front());
        end
        if (n_rst && ss2) begin
            run2++;
        end else if (run2 > 0) begin
            n_checks++;
            if (run2 < 2) begin
                n_fail++;
                $display("FAIL ss_gap_d2: SS high for %0d cycles, required >= 2", run2);
            end
            run2 = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] d, input logic l, input bit garbage, output int t_acc);
        int n = 0;
        @(negedge clk);
        while (!bus4.tx_ready && n < 3000) begin
            if (garbage) begin
                bus4.tx_valid = 1'($urandom);
                bus4.tx_data  = 8'($urandom);
                bus4.tx_last  = 1'($urandom);
            end else begin
                bus4.tx_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("tx_ready_wait");
        bus4.tx_valid = 1'b1;
        bus4.tx_data  = d;
        bus4.tx_last  = l;
        t_acc = cyc;
        @(negedge clk);
        bus4.tx_valid = 1'b0;
        bus4.tx_data  = 8'h00;
        bus4.tx_last  = 1'b0;
    endtask

    task automatic wait_idle4();
        int n = 0;
        @(negedge clk);
        while (busy4 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("idle_wait");
        @(negedge clk);
    endtask

    task automatic queue_byte(input logic [7:0] d, input logic [7:0] r, input logic l);
        exp_mosi_q.push_back(d);
        exp_rx_q.push_back(r);
        miso_q.push_back({l, r});
    endtask

    task automatic send_frame_rand(input int nbytes, input bit garbage);
        logic [7:0] d[$];
        int t;
        for (int i = 0; i < nbytes; i++) begin
            d.push_back(8'($urandom));
            queue_byte(d[i], 8'($urandom), (i == nbytes - 1));
        end
        for (int i = 0; i < nbytes; i++) send_byte(d[i], (i == nbytes - 1), garbage, t);
        wait_idle4();
    endtask

    initial begin
        int t0, base_rx, base_sck, n, stall_bad;
        bus4.tx_valid = 1'b0; bus4.tx_data = 8'h00; bus4.tx_last = 1'b0;
        bus2.tx_valid = 1'b0; bus2.tx_data = 8'h00; bus2.tx_last = 1'b0;

        // reset state
        #23;
        chk("rst_sck", sck4, 1'b0);
        chk("rst_ss", ss4, 1'b1);
        chk("rst_mosi", mosi4, 1'b0);
        chk("rst_rx_valid", bus4.rx_valid, 1'b0);
        chk("rst_rx_data", bus4.rx_data, 8'h00);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_tx_ready", bus4.tx_ready, 1'b1);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // single byte, exact timing at D=4
        queue_byte(8'hA5, 8'h3C, 1'b1);
        send_byte(8'hA5, 1'b1, 1'b0, t0);
        wait_idle4();
        chk("single_rx_valid_cycle", rx_cyc4 - t0, 65);
        chk("single_ss_rise_cycle", ss_rise_cyc4 - t0, 69);
        chk("single_tx_ready_cycle", ready_rise_cyc4 - t0, 73);
        chk("single_rx_data_held", bus4.rx_data, 8'h3C);

        // two-byte frame, back to back
        base_rx = rx_cnt4; base_sck = sck_rises4;
        queue_byte(8'h01, 8'($urandom), 1'b0);
        queue_byte(8'hFF, 8'($urandom), 1'b1);
        send_byte(8'h01, 1'b0, 1'b0, t0);
        send_byte(8'hFF, 1'b1, 1'b0, t0);
        chk("two_ss_low_second_byte", ss4, 1'b0);
        wait_idle4();
        chk("two_sck_rises", sck_rises4 - base_sck, 16);
        chk("two_rx_strobes", rx_cnt4 - base_rx, 2);

        // stall in GAP for 50 cycles
        base_rx = rx_cnt4;
        queue_byte(8'h5A, 8'($urandom), 1'b0);
        queue_byte(8'hC3, 8'($urandom), 1'b1);
        send_byte(8'h5A, 1'b0, 1'b0, t0);
        n = 0;
        while (!bus4.tx_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail_now("gap_wait");
        stall_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (sck4 !== 1'b0 || ss4 !== 1'b0 || busy4 !== 1'b1) stall_bad++;
        end
        chk("gap_stall_pins", stall_bad, 0);
        send_byte(8'hC3, 1'b1, 1'b0, t0);
        wait_idle4();
        chk("gap_rx_strobes", rx_cnt4 - base_rx, 2);

        // ignored input while shifting
        base_rx = rx_cnt4;
        send_frame_rand(3, 1'b1);
        chk("garbage_rx_strobes", rx_cnt4 - base_rx, 3);

        // random frames
        for (int f = 0; f < 4; f++) send_frame_rand(1 + int'($urandom_range(0, 3)), 1'($urandom));

        // reset mid-byte after the third rising edge
        base_rx = rx_cnt4; base_sck = sck_rises4;
        queue_byte(8'hFF, 8'($urandom), 1'b1);
        send_byte(8'hFF, 1'b1, 1'b0, t0);
        n = 0;
        while (sck_rises4 - base_sck < 3 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail_now("third_edge_wait");
        #2 n_rst = 1'b0;
        #1;
        chk("abort_ss", ss4, 1'b1);
        chk("abort_sck", sck4, 1'b0);
        chk("abort_mosi", mosi4, 1'b0);
        repeat (3) @(negedge clk);
        exp_mosi_q.delete(); exp_rx_q.delete(); miso_q.delete();
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_tx_ready", bus4.tx_ready, 1'b1);
        chk("abort_busy", busy4, 1'b0);
        chk("abort_no_rx", rx_cnt4 - base_rx, 0);

        // recovery after reset
        send_frame_rand(2, 1'b0);

        // frame spacing at D=2
        for (int f = 0; f < 6; f++) begin
            logic [7:0] d;
            d = 8'($urandom);
            @(negedge clk);
            n = 0;
            while (!bus2.tx_ready && n < 500) begin @(negedge clk); n++; end
            if (n >= 500) fail_now("d2_ready_wait");
            rep2 = 8'($urandom);
            exp_rx2_q.push_back(rep2);
            exp_mosi2_q.push_back(d);
            bus2.tx_valid = 1'b1; bus2.tx_data = d; bus2.tx_last = 1'b1;
            @(negedge clk);
            bus2.tx_valid = 1'b0;
        end
        n = 0;
        while ((busy2 || exp_rx2_q.size() > 0) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) fail_now("d2_drain_wait");

        repeat (4) @(negedge clk);
        chk("drain_mosi_q", exp_mosi_q.size(), 0);
        chk("drain_rx_q", exp_rx_q.size(), 0);
        chk("drain_rx2_q", exp_rx2_q.size(), 0);
        chk("drain_mosi2_q", exp_mosi2_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
